// File: rtl/stream_accum_pkg.sv
// Shared types, default sizes and helpers for the stream accumulator.
// Default sizes match the 8-bit adder datapath feeding the accumulator.
package stream_accum_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 12;
  localparam int DEF_MAX_OPS = 16;
  localparam int MAX_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Keeps the low w bits of d and clears the rest; callers cast to their own width.
  function automatic logic [MAX_W-1:0] zext_data(input logic [MAX_W-1:0] d, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = (i < w) ? d[i] : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_add_slice.sv
// Combinational W-bit adder with carry in and carry out for the accumulate path.
// No state, no handshake: the result is valid in the same cycle as its inputs.
module accum_add_slice #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  assign full = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/stream_accumulator.sv
// Sums a packet of operands (closed by in_last or MAX_OPS) and holds the result until out_ready;
// result appears the cycle after the closing beat, input stalls while it is held. ACCUM_SAT_EN clamps on carry.
module stream_accumulator
  import stream_accum_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_OPS = DEF_MAX_OPS,
  localparam int CNT_W  = $clog2(MAX_OPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic [ACC_W-1:0] operand;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic             cout;
  logic [ACC_W-1:0] next_acc;
  logic [CNT_W-1:0] next_count;
  logic             next_ovf;
  logic             take;
  logic             close;

  // The first beat of a packet adds onto zero, so one adder serves both load and accumulate.
  always_comb begin
    operand    = ACC_W'(zext_data(MAX_W'(in_data), DATA_W));
    base       = (state == ACCUM) ? acc : '0;
    next_count = (state == ACCUM) ? count + CNT_W'(1) : CNT_W'(1);
    next_ovf   = ((state == ACCUM) ? ovf : 1'b0) | cout;
`ifdef ACCUM_SAT_EN
    next_acc   = cout ? '1 : sum;
`else
    next_acc   = sum;
`endif
    take       = in_valid && in_ready;
    close      = in_last || (next_count == CNT_W'(MAX_OPS));
  end

  accum_add_slice #(
    .W(ACC_W)
  ) u_add (
    .a    (base),
    .b    (operand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (take) begin
            acc   <= next_acc;
            count <= next_count;
            ovf   <= next_ovf;
            if (close) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= next_acc;
              out_count <= next_count;
              out_ovf   <= next_ovf;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  a_ready_excl: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_sum) && $stable(out_count) && $stable(out_ovf)));

endmodule

// File: tb/tb_stream_accumulator.sv
// Drives a 12-bit and an 8-bit accumulator in lockstep and checks them against a packet-sum model.
module tb_stream_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [11:0] w_out_sum;
  logic [4:0]  w_out_count;
  logic        n_in_ready, n_out_valid, n_out_ovf;
  logic [7:0]  n_out_sum;
  logic [4:0]  n_out_count;

  int checks = 0;
  int passed = 0;
  logic [7:0] pkt[$];

  always #5 clk = ~clk;

  stream_accumulator #(.DATA_W(8), .ACC_W(12), .MAX_OPS(16)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(w_out_valid), .out_ready(out_ready), .out_sum(w_out_sum),
    .out_count(w_out_count), .out_ovf(w_out_ovf)
  );

  stream_accumulator #(.DATA_W(8), .ACC_W(8), .MAX_OPS(16)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(n_out_valid), .out_ready(out_ready), .out_sum(n_out_sum),
    .out_count(n_out_count), .out_ovf(n_out_ovf)
  );

  // Expected {sum, count, ovf} for the operands in pkt, for an accumulator w bits wide.
  function automatic logic [17:0] model(input int w);
    int total;
    logic o;
    logic [11:0] s;
    total = 0;
    foreach (pkt[i]) total += int'(pkt[i]);
    o = (total >= (1 << w));
`ifdef ACCUM_SAT_EN
    s = o ? 12'((1 << w) - 1) : 12'(total);
`else
    s = 12'(total % (1 << w));
`endif
    return {s, 5'(pkt.size()), o};
  endfunction

  // Sends pkt beat by beat; timing_ok drops if out_valid is early/late or a beat never transfers.
  task automatic send_pkt(input bit tag_last, input int idle_pct, output bit timing_ok);
    bit rdy;
    int guard;
    timing_ok = 1'b1;
    for (int i = 0; i < pkt.size(); i++) begin
      if (int'($urandom_range(99)) < idle_pct) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = tag_last && (i == pkt.size() - 1);
      guard = 0;
      forever begin
        rdy = w_in_ready;
        if (w_out_valid !== 1'b0 || n_out_valid !== 1'b0) timing_ok = 1'b0;
        @(negedge clk);
        if (rdy) break;
        guard++;
        if (guard > 40) begin
          timing_ok = 1'b0;
          break;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (w_out_valid !== 1'b1 || n_out_valid !== 1'b1) timing_ok = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({w_in_ready, w_out_valid, w_out_sum, w_out_count, w_out_ovf} !== {1'b1, 1'b0, 18'd0})
      $display("FAIL reset_wide: got rdy=%b vld=%b sum=%h cnt=%0d ovf=%b, want rdy=1 vld=0 zeros",
               w_in_ready, w_out_valid, w_out_sum, w_out_count, w_out_ovf);
    else passed++;
    checks++;
    if ({n_in_ready, n_out_valid, n_out_sum, n_out_count, n_out_ovf} !== {1'b1, 1'b0, 14'd0})
      $display("FAIL reset_narrow: got rdy=%b vld=%b sum=%h cnt=%0d ovf=%b, want rdy=1 vld=0 zeros",
               n_in_ready, n_out_valid, n_out_sum, n_out_count, n_out_ovf);
    else passed++;
  endtask

  task automatic test_basic();
    bit t;
    pkt = '{8'd10, 8'd20, 8'd30};
    send_pkt(1'b1, 0, t);
    checks++;
    if (t !== 1'b1) $display("FAIL basic_latency: timing_ok=%b want 1", t); else passed++;
    checks++;
    if ({w_out_sum, w_out_count, w_out_ovf} !== {12'd60, 5'd3, 1'b0})
      $display("FAIL basic_result: got sum=%0d cnt=%0d ovf=%b want 60 3 0", w_out_sum, w_out_count, w_out_ovf);
    else passed++;
    release_out();
    checks++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1)
      $display("FAIL basic_release: got vld=%b rdy=%b want 0 1", w_out_valid, w_in_ready);
    else passed++;
  endtask

  task automatic test_auto_close();
    bit t;
    pkt = {};
    repeat (16) pkt.push_back(8'hFF);
    send_pkt(1'b0, 0, t);
    checks++;
    if (t !== 1'b1) $display("FAIL auto_close_latency: timing_ok=%b want 1", t); else passed++;
    checks++;
    if ({w_out_sum, w_out_count, w_out_ovf} !== {12'hFF0, 5'd16, 1'b0})
      $display("FAIL auto_close_result: got sum=%h cnt=%0d ovf=%b want ff0 16 0", w_out_sum, w_out_count, w_out_ovf);
    else passed++;
    checks++;
    if (w_in_ready !== 1'b0) $display("FAIL auto_close_stall: in_ready=%b want 0", w_in_ready); else passed++;
    release_out();
  endtask

  task automatic test_overflow();
    bit t;
    logic [17:0] exp_n;
    pkt = {};
    repeat (16) pkt.push_back(8'hFF);
    exp_n = model(8);
    send_pkt(1'b0, 0, t);
    checks++;
    if ({4'd0, n_out_sum, n_out_count, n_out_ovf} !== exp_n || exp_n[0] !== 1'b1)
      $display("FAIL ovf_pkt1: got sum=%h cnt=%0d ovf=%b want %h %0d %b",
               n_out_sum, n_out_count, n_out_ovf, exp_n[17:6], exp_n[5:1], exp_n[0]);
    else passed++;
    release_out();
    pkt = '{8'hFF};
    exp_n = model(8);
    send_pkt(1'b1, 0, t);
    checks++;
    if ({4'd0, n_out_sum, n_out_count, n_out_ovf} !== exp_n || t !== 1'b1)
      $display("FAIL ovf_pkt2: got sum=%h cnt=%0d ovf=%b t=%b want %h %0d %b",
               n_out_sum, n_out_count, n_out_ovf, t, exp_n[17:6], exp_n[5:1], exp_n[0]);
    else passed++;
    release_out();
  endtask

  task automatic test_backpressure();
    bit t;
    logic [17:0] exp_w;
    pkt = {};
    repeat (3) pkt.push_back(8'($urandom));
    exp_w = model(12);
    send_pkt(1'b1, 0, t);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (w_out_valid !== 1'b1 || w_in_ready !== 1'b0 || {w_out_sum, w_out_count, w_out_ovf} !== exp_w)
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b sum=%h cnt=%0d want 1 0 %h %0d",
                 c, w_out_valid, w_in_ready, w_out_sum, w_out_count, exp_w[17:6], exp_w[5:1]);
      else passed++;
      @(negedge clk);
    end
    release_out();
    pkt = {8'h55};
    repeat (3) pkt.push_back(8'($urandom));
    exp_w = model(12);
    send_pkt(1'b1, 0, t);
    checks++;
    if ({w_out_sum, w_out_count, w_out_ovf} !== exp_w || t !== 1'b1)
      $display("FAIL hold_next_pkt: got sum=%h cnt=%0d ovf=%b t=%b want %h %0d %b",
               w_out_sum, w_out_count, w_out_ovf, t, exp_w[17:6], exp_w[5:1], exp_w[0]);
    else passed++;
    release_out();
  endtask

  task automatic test_reset_mid();
    bit t;
    pkt = '{8'd100, 8'd200};
    send_pkt(1'b0, 0, t);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({w_out_valid, w_out_sum, w_out_count, w_out_ovf} !== 19'd0 || w_in_ready !== 1'b0)
      $display("FAIL rst_accum: got vld=%b rdy=%b sum=%h cnt=%0d want all 0", w_out_valid, w_in_ready, w_out_sum, w_out_count);
    else passed++;
    @(negedge clk);
    pkt = '{8'd1, 8'd2};
    send_pkt(1'b1, 0, t);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({w_out_valid, w_out_sum, w_out_count, w_out_ovf} !== 19'd0)
      $display("FAIL rst_hold: got vld=%b sum=%h cnt=%0d ovf=%b want all 0", w_out_valid, w_out_sum, w_out_count, w_out_ovf);
    else passed++;
    @(negedge clk);
    pkt = '{8'd5, 8'd7};
    send_pkt(1'b1, 0, t);
    checks++;
    if ({w_out_sum, w_out_count, w_out_ovf} !== {12'd12, 5'd2, 1'b0} || t !== 1'b1)
      $display("FAIL rst_after: got sum=%0d cnt=%0d ovf=%b t=%b want 12 2 0", w_out_sum, w_out_count, w_out_ovf, t);
    else passed++;
    release_out();
  endtask

  task automatic test_random();
    bit t, tag;
    int n;
    logic [17:0] exp_w, exp_n;
    for (int p = 0; p < 20; p++) begin
      n = int'($urandom_range(16, 1));
      pkt = {};
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      tag = (n < 16) ? 1'b1 : 1'($urandom);
      exp_w = model(12);
      exp_n = model(8);
      send_pkt(tag, 30, t);
      checks++;
      if ({w_out_sum, w_out_count, w_out_ovf} !== exp_w || {4'd0, n_out_sum, n_out_count, n_out_ovf} !== exp_n || t !== 1'b1)
        $display("FAIL random_pkt%0d: got w=%h/%0d/%b n=%h/%0d/%b t=%b want w=%h/%0d/%b n=%h/%0d/%b", p,
                 w_out_sum, w_out_count, w_out_ovf, n_out_sum, n_out_count, n_out_ovf, t,
                 exp_w[17:6], exp_w[5:1], exp_w[0], exp_n[17:6], exp_n[5:1], exp_n[0]);
      else passed++;
      repeat (int'($urandom_range(3))) @(negedge clk);
      release_out();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_auto_close();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
